// File: rtl/pipelined_chunk_adder_if.sv
// Handshake bus for pipelined_chunk_adder.
// Request side: in_valid/in_ready with operands x, y, carryin and sub.
// Response side: out_valid/out_ready with result out, carryout and overflow.
// master = producer of operands / consumer of results; slave = the adder.
interface pipelined_chunk_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carryin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carryout;
  logic             overflow;

  modport master (
    output in_valid, x, y, carryin, sub, out_ready,
    input  in_ready, out_valid, out, carryout, overflow
  );

  modport slave (
    input  in_valid, x, y, carryin, sub, out_ready,
    output in_ready, out_valid, out, carryout, overflow
  );
endinterface

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract resolved CHUNK bits per stage.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of pipelined_chunk_adder_if: operands in (valid/ready),
//          out/carryout/overflow back (valid/ready). in_ready is combinational.
// Stage k adds chunk k with the carry registered by stage k-1. Each stage
// register carries one vector: the finished low sum chunks and the not yet
// consumed x chunks in the low WIDTH bits, and the remaining effective-y
// chunks above them, so the word narrows by CHUNK bits per stage.
module pipelined_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  pipelined_chunk_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned CW     = CHUNK + 1;

  // Reject widths that cannot be split into whole chunks.
  if (CHUNK == 0 || WIDTH == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $fatal(1, "pipelined_chunk_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  logic             stall_c;
  logic             last_load;
  logic             ovf_n;
  logic             ovf_q;
  logic [WIDTH-1:0] eff_y;

  assign eff_y = bus.sub ? ~bus.y : bus.y;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int unsigned DWP = WIDTH + (STAGES - k) * CHUNK;
    localparam int unsigned DW  = WIDTH + (STAGES - 1 - k) * CHUNK;

    logic [DWP-1:0]   p;
    logic             cin;
    logic             vin;
    logic [CHUNK:0]   r;
    logic [WIDTH-1:0] low_n;
    logic [DW-1:0]    d_n;
    logic [DW-1:0]    d_q;
    logic             c_q;
    logic             v_q;

    // Stage input: either the bus or the previous stage register.
    if (k == 0) begin : g_head
      assign p   = {eff_y, bus.x};
      assign cin = bus.sub | bus.carryin;
      assign vin = bus.in_valid;
    end else begin : g_body
      assign p   = g_st[k-1].d_q;
      assign cin = g_st[k-1].c_q;
      assign vin = g_st[k-1].v_q;
    end

    // Chunk k of x sits at its natural position; chunk k of eff_y is the
    // lowest chunk above the WIDTH-bit field.
    assign r = CW'(p[k*CHUNK +: CHUNK]) + CW'(p[WIDTH +: CHUNK]) + CW'(cin);

    always_comb begin
      low_n                    = p[WIDTH-1:0];
      low_n[k*CHUNK +: CHUNK]  = r[CHUNK-1:0];
    end

    if (k < STAGES - 1) begin : g_skew
      assign d_n = {p[DWP-1:WIDTH+CHUNK], low_n};
    end else begin : g_tail
      assign d_n       = low_n;
      // Same operand signs and a result sign that differs means overflow.
      assign ovf_n     = (p[k*CHUNK+CHUNK-1] == p[WIDTH+CHUNK-1]) &&
                         (r[CHUNK-1] != p[k*CHUNK+CHUNK-1]);
      assign last_load = vin && !stall_c;
    end

    // Stage register: whole pipeline holds on stall; data loads only with valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        d_q <= '0;
        c_q <= 1'b0;
      end else if (!stall_c) begin
        v_q <= vin;
        if (vin) begin
          d_q <= d_n;
          c_q <= r[CHUNK];
        end
      end
    end
  end

  // Overflow flag registered alongside the final stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_load) begin
      ovf_q <= ovf_n;
    end
  end

  assign stall_c      = g_st[STAGES-1].v_q && !bus.out_ready;
  assign bus.in_ready = !stall_c;
  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.out       = g_st[STAGES-1].d_q;
  assign bus.carryout  = g_st[STAGES-1].c_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Bench for pipelined_chunk_adder: four instances with (WIDTH,CHUNK) =
// (16,4), (4,4), (8,2), (32,8) share one operand stream (truncated per width)
// and one out_ready. Each instance has its own scoreboard and monitor.
module tb_pipelined_chunk_adder;
  localparam int NI = 4;

  function automatic int unsigned w_of(input int i);
    case (i)
      0:       return 16;
      1:       return 4;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int unsigned c_of(input int i);
    case (i)
      0:       return 4;
      1:       return 4;
      2:       return 2;
      default: return 8;
    endcase
  endfunction

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_all;
  logic [31:0]   x_all;
  logic [31:0]   y_all;
  logic          cin_all;
  logic          sub_all;
  logic          out_ready_all;
  logic          final_check;
  wire  [NI-1:0] rdy;
  wire           all_ready;
  int            n_vec_main = 0;
  int            n_err_main = 0;

  always #5 clk = ~clk;

  // Operands are offered only when every instance can take them, so all
  // instances see the identical transfer sequence.
  assign all_ready = &rdy;

  for (genvar g = 0; g < NI; g++) begin : g_i
    localparam int unsigned W = w_of(g);
    localparam int unsigned C = c_of(g);
    localparam int unsigned S = W / C;

    pipelined_chunk_adder_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid_all & all_ready;
    assign bus.x         = x_all[W-1:0];
    assign bus.y         = y_all[W-1:0];
    assign bus.carryin   = cin_all;
    assign bus.sub       = sub_all;
    assign bus.out_ready = out_ready_all;
    assign rdy[g]        = bus.in_ready;

    pipelined_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );

    // Reference: plain integer arithmetic; overflow from the signed range.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
      longint unsigned mask, ub, tot;
      longint          sa, sb, st, hi, lo;
      logic            co, ov;
      logic [W-1:0]    r;
      mask = (64'd1 << W) - 64'd1;
      ub   = s ? (mask - 64'(b)) : 64'(b);
      tot  = 64'(a) + ub + (s ? 64'd1 : 64'(c));
      r    = W'(tot);
      co   = (tot >> W) != 0;
      sa   = a[W-1] ? longint'(a) - longint'(mask) - 1 : longint'(a);
      sb   = b[W-1] ? longint'(b) - longint'(mask) - 1 : longint'(b);
      st   = s ? (sa - sb) : (sa + sb + longint'(c));
      hi   = longint'(mask >> 1);
      lo   = -hi - 1;
      ov   = (st > hi) || (st < lo);
      return {ov, co, r};
    endfunction

    logic [W+1:0] exp_q[$];
    int           iss_q[$];
    int           stl_q[$];
    int           cyc = 0;
    int           stalls = 0;
    int           n_vec = 0;
    int           n_err = 0;
    bit           prev_stall = 1'b0;
    bit           done = 1'b0;
    logic [W+1:0] prev_o = '0;

    task automatic chk(input string nm, input longint unsigned got, input longint unsigned want);
      n_vec++;
      if (got != want) begin
        n_err++;
        $display("FAIL w%0d/c%0d %s: got %0h want %0h (cycle %0d)", W, C, nm, got, want, cyc);
      end
    endtask

    // Monitor: sample mid-cycle, ahead of the next rising edge.
    always @(negedge clk) begin
      logic [W+1:0] cur;
      bit           stall;
      cur = {bus.overflow, bus.carryout, bus.out};
      if (!rst_n) begin
        chk("reset out_valid", 64'(bus.out_valid), 0);
        chk("reset in_ready", 64'(bus.in_ready), 1);
        chk("reset result", 64'(cur), 0);
        exp_q.delete();
        iss_q.delete();
        stl_q.delete();
        prev_stall = 1'b0;
      end else begin
        stall = bus.out_valid && !bus.out_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(!stall));
        if (bus.out_valid) begin
          if (prev_stall) begin
            chk("held result", 64'(cur), 64'(prev_o));
          end else begin
            chk("result pending", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
              chk("result", 64'(cur), 64'(exp_q[0]));
              chk("latency", 64'(cyc - iss_q[0]), 64'(S + (stalls - stl_q[0])));
            end
          end
          prev_o = cur;
        end
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          void'(iss_q.pop_front());
          void'(stl_q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(bus.x, bus.y, bus.carryin, bus.sub));
          iss_q.push_back(cyc);
          stl_q.push_back(stalls);
        end
        if (stall) stalls++;
        prev_stall = stall;
      end
      cyc++;
      if (final_check && !done) begin
        done = 1'b1;
        chk("results left undelivered", 64'(exp_q.size()), 0);
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
    int k;
    x_all        = a;
    y_all        = b;
    cin_all      = c;
    sub_all      = s;
    in_valid_all = 1'b1;
    k = 0;
    @(negedge clk);
    while (!all_ready && k < 64) begin
      @(negedge clk);
      k++;
    end
    n_vec_main++;
    if (!all_ready) begin
      n_err_main++;
      $display("FAIL send accept: got ready=%b want 1 after %0d cycles", all_ready, k);
    end
    @(posedge clk);
    #1;
    in_valid_all = 1'b0;
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8888_8888;
      3:       return 32'h7777_7777;
      default: return $urandom();
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit rand_done = 1'b0;

  initial begin
    int tv, te;
    rst_n         = 1'b1;
    in_valid_all  = 1'b0;
    x_all         = '0;
    y_all         = '0;
    cin_all       = 1'b0;
    sub_all       = 1'b0;
    out_ready_all = 1'b1;
    final_check   = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed cases, isolated so latency is visible.
    send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(6);
    send(32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0);
    idle(6);
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    send(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1);
    send(32'h0000_0FFF, 32'h0000_F000, 1'b1, 1'b0);
    idle(10);

    // Back-to-back stream with a 3-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 10; i++) send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      begin
        idle(5);
        out_ready_all = 1'b0;
        idle(3);
        out_ready_all = 1'b1;
      end
    join
    idle(12);

    // Reset with operations in flight; nothing from them may emerge.
    for (int i = 0; i < 3; i++) send($urandom(), $urandom(), 1'b0, 1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0);
    idle(12);

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready_all = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready_all = 1'b1;
    idle(50);
    final_check = 1'b1;
    repeat (2) @(negedge clk);

    tv = n_vec_main + g_i[0].n_vec + g_i[1].n_vec + g_i[2].n_vec + g_i[3].n_vec;
    te = n_err_main + g_i[0].n_err + g_i[1].n_err + g_i[2].n_err + g_i[3].n_err;
    $display("== %0d vectors applied, %0d miscompares ==", tv, te);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipelined_chunk_adder.md
Name: pipelined_chunk_adder

Overview:
- Parametrised, pipelined successor to the team's 4-bit ripple adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit ripple segments, one segment per pipeline stage, with the carry registered between stages.
- Adds a signed-overflow flag, a subtract mode, and valid/ready handshakes on input and output.
- Sits in the datapath wherever a wide adder must close timing at full clock rate.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4: bits resolved per stage; STAGES = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- in_ready  output  1  block accepts operands this cycle
- x  input  WIDTH  operand A, unsigned or two's complement
- y  input  WIDTH  operand B
- carryin  input  1  carry into bit 0; used only when sub=0
- sub  input  1  0: x+y+carryin; 1: x-y, computed as x+~y+1
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  WIDTH  sum/difference
- carryout  output  1  carry out of the MSB (for sub: 1 = no borrow)
- overflow  output  1  signed overflow

Behaviour:
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - STAGES register stages, each with its own valid bit.
  - Stage k adds chunk k of x and (sub ? ~y : y) plus the carry registered from stage k-1.
  - Stage 0 carry-in is (sub ? 1 : carryin).
  - Upper operand chunks travel forward in skew registers.
  - Completed lower sum chunks travel forward in deskew registers, so all chunks emerge aligned.
- Latency: exactly STAGES cycles from input transfer to out_valid, with no stall.
- Throughput: one operation per cycle while out_ready=1.
- Backpressure:
  - stall = out_valid && !out_ready.
  - On stall, all stage registers and valid bits hold.
  - in_ready = !stall, which is combinational from out_valid and out_ready.
  - Bubbles do not compress: the pipeline is all-or-nothing.
- Held outputs: while out_valid=1 && out_ready=0, out, carryout and overflow stay stable.
- Bubble handling:
  - A stage whose valid bit is 0 may hold stale data.
  - out, carryout and overflow are don't-care while out_valid=0.
- carryout: the carry out of bit WIDTH-1 of the final stage.
- overflow: carry into the MSB XOR carry out of the MSB. This equals "sign of x equals sign of the effective B and sign of out differs from it".
- Arithmetic:
  - Results are modulo 2^WIDTH.
  - sub=1 with y=0 gives out=x, carryout=1.
- Reset (async assert, sync release):
  - All valid bits go to 0, so out_valid=0.
  - out, carryout and overflow go to 0; all internal registers clear.
  - in_ready=1 during and after reset.
  - Reset mid-operation discards every in-flight operation; none emerges afterwards.
- Degenerate case: CHUNK=WIDTH gives STAGES=1, latency 1, and must still work.
- Illegal parameters: an elaboration-time check must fail when WIDTH % CHUNK != 0.

Test Plan:
- Reset then single op, WIDTH=16/CHUNK=4, sub=0:
  - Drive x=0xFFFF, y=0x0001, carryin=0.
  - Require out_valid exactly 4 cycles later, out=0x0000, carryout=1, overflow=0.
- Signed overflow, sub=0:
  - Drive x=0x7FFF, y=0x0001, carryin=0 → out=0x8000, carryout=0, overflow=1.
- Subtract:
  - x=0x0005, y=0x0007, sub=1 → out=0xFFFE, carryout=0 (borrow), overflow=0.
  - x=0x8000, y=0x0001, sub=1 → out=0x7FFF, overflow=1.
- Streaming with backpressure:
  - Issue 10 back-to-back random ops; hold out_ready=0 for 3 cycles mid-stream.
  - Require in_ready=0 during the stall and outputs stable while held.
  - Require no lost or duplicated results and in-order match against a reference model.
- Reset mid-flight:
  - Issue 3 ops, then assert rst_n=0 for 1 cycle after 2 cycles.
  - Require out_valid=0 immediately and no result from those 3 ops afterwards.
  - A new op must complete with normal latency.
- Parameter sweep:
  - Rerun random add/sub checks with (WIDTH,CHUNK) = (4,4), (8,2), (32,8).
  - Require latency = WIDTH/CHUNK and results exact, including carryin=1 cases.
